// File: rtl/fir_sched_pkg.sv
// Shared types and arithmetic helpers for the single-DSP FIR MAC scheduler.
package fir_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } sched_st_t;

  localparam int TAP_W = 7;

  // Headroom of 7 bits covers up to 127 full-scale products.
  function automatic int acc_width(input int dw, input int cw);
    return dw + cw + TAP_W;
  endfunction

  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] acc,
                                                   input int shift, input int dw);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = acc >>> shift;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/fir_mac_sched_rr_arbiter.sv
// Round-robin arbiter: search starts at the priority pointer, which moves past the winner on accept.
module rr_arbiter
  import fir_sched_pkg::*;
#(
  parameter int N_REQ = 3,
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             accept,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    index,
  output logic             valid
);

  logic [IW-1:0] ptr;
  int            cand;

  always_comb begin
    grant = '0;
    index = '0;
    valid = 1'b0;
    cand  = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = (int'(ptr) + i) % N_REQ;
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        grant[cand] = 1'b1;
        index       = IW'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (int'(index) == N_REQ - 1) ? '0 : index + IW'(1);
    end
  end

endmodule

// File: rtl/fir_mac_sched.sv
// Shared MAC scheduler: arbitrates FIR stage jobs, streams taps through one multiplier,
// and returns a scaled, saturated result tagged with the requester.
//
// state   | meaning
// S_IDLE  | waiting for a request; grant and capture descriptor on the way out
// S_RUN   | one tap read issued per cycle, down-counter tracks remaining taps
// S_DRAIN | last product lands in the accumulator, result is formed
// S_DONE  | result pulse is on the outputs; back to idle next
module fir_mac_sched
  import fir_sched_pkg::*;
#(
  parameter int N_REQ      = 3,
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int AW         = 6,
  parameter int CAW        = 8,
  parameter int TAP_MAX    = 63,
  parameter int SHIFT      = 15,
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*AW-1:0]     job_base,
  input  logic [N_REQ*CAW-1:0]    job_coef,
  input  logic [N_REQ*7-1:0]      job_taps,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy,
  output logic                    rd_en,
  output logic [IW-1:0]           rd_sel,
  output logic [AW-1:0]           smp_addr,
  output logic [CAW-1:0]          coef_addr,
  input  logic [DATA_WIDTH-1:0]   smp_q,
  input  logic [COEF_WIDTH-1:0]   coef_q,
  output logic                    res_valid,
  output logic [IW-1:0]           res_id,
  output logic [DATA_WIDTH-1:0]   res_data
);

  localparam int ACC_W  = acc_width(DATA_WIDTH, COEF_WIDTH);
  localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;

  sched_st_t                  state;
  logic [N_REQ-1:0]           win_oh;
  logic [IW-1:0]              win_idx;
  logic                       win_any;
  logic                       accept;
  logic [TAP_W-1:0]           taps_raw;
  logic [TAP_W-1:0]           taps_eff;
  logic [TAP_W-1:0]           remain;
  logic                       mac_vld;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    acc_next;
  logic signed [63:0]         acc_wide;

  assign accept = (state == S_IDLE) && win_any;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .accept (accept),
    .grant  (win_oh),
    .index  (win_idx),
    .valid  (win_any)
  );

  assign taps_raw = job_taps[int'(win_idx)*TAP_W +: TAP_W];
  assign taps_eff = (taps_raw > TAP_W'(TAP_MAX)) ? TAP_W'(TAP_MAX) : taps_raw;

  // Memory read data arrives one cycle after rd_en, so mac_vld is rd_en delayed.
  assign prod     = $signed(smp_q) * $signed(coef_q);
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign acc_next = mac_vld ? acc + prod_ext : acc;
  assign acc_wide = {{(64-ACC_W){acc_next[ACC_W-1]}}, acc_next};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      grant     <= '0;
      busy      <= 1'b0;
      rd_en     <= 1'b0;
      rd_sel    <= '0;
      smp_addr  <= '0;
      coef_addr <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_data  <= '0;
      remain    <= '0;
      mac_vld   <= 1'b0;
      acc       <= '0;
    end else begin
      grant     <= '0;
      res_valid <= 1'b0;
      mac_vld   <= rd_en;
      acc       <= acc_next;
      case (state)
        S_IDLE: begin
          if (win_any) begin
            grant     <= win_oh;
            busy      <= 1'b1;
            rd_sel    <= win_idx;
            smp_addr  <= job_base[int'(win_idx)*AW +: AW];
            coef_addr <= job_coef[int'(win_idx)*CAW +: CAW];
            rd_en     <= (taps_eff != '0);
            remain    <= (taps_eff == '0) ? '0 : taps_eff - TAP_W'(1);
            acc       <= '0;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (remain == '0) begin
            rd_en <= 1'b0;
            state <= S_DRAIN;
          end else begin
            smp_addr  <= smp_addr - AW'(1);
            coef_addr <= coef_addr + CAW'(1);
            remain    <= remain - TAP_W'(1);
          end
        end
        S_DRAIN: begin
          res_valid <= 1'b1;
          res_id    <= rd_sel;
          res_data  <= DATA_WIDTH'(sat_shift(acc_wide, SHIFT, DATA_WIDTH));
          state     <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sched.sv
// Directed bench for fir_mac_sched with registered sample/coefficient memory models.
module tb_fir_mac_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [17:0] job_base;
  logic [23:0] job_coef;
  logic [20:0] job_taps;
  logic [2:0]  grant;
  logic        busy, rd_en, res_valid;
  logic [1:0]  rd_sel, res_id;
  logic [5:0]  smp_addr;
  logic [7:0]  coef_addr;
  logic [15:0] smp_q, coef_q, res_data;

  logic [15:0] smem [3][64];
  logic [15:0] cmem [256];

  int total = 0;
  int bad   = 0;

  int g_gcyc, g_rcyc, g_nrd, g_id;
  logic [15:0] g_data;
  logic g_busy_res, g_busy_after;
  int saddr_q[$];
  int caddr_q[$];

  fir_mac_sched dut (
    .clk(clk), .rst(rst), .req(req), .job_base(job_base), .job_coef(job_coef),
    .job_taps(job_taps), .grant(grant), .busy(busy), .rd_en(rd_en), .rd_sel(rd_sel),
    .smp_addr(smp_addr), .coef_addr(coef_addr), .smp_q(smp_q), .coef_q(coef_q),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) begin
      smp_q  <= smem[rd_sel][smp_addr];
      coef_q <= cmem[coef_addr];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int s = 0; s < 3; s++)
      for (int a = 0; a < 64; a++) smem[s][a] = 16'h0000;
    for (int a = 0; a < 256; a++) cmem[a] = 16'h0000;
  endtask

  // Posts one job for a single stage and records what the DUT did until its result.
  task automatic run_job(input int stage, input int base, input int cbase, input int taps);
    saddr_q.delete();
    caddr_q.delete();
    g_gcyc = -1; g_rcyc = -1; g_nrd = 0; g_id = -1; g_data = 16'hxxxx;
    g_busy_res = 1'b0; g_busy_after = 1'b1;
    job_base[stage*6 +: 6] = base[5:0];
    job_coef[stage*8 +: 8] = cbase[7:0];
    job_taps[stage*7 +: 7] = taps[6:0];
    req[stage] = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      step();
      if (grant[stage] && g_gcyc < 0) begin
        g_gcyc = n;
        req[stage] = 1'b0;
      end
      if (rd_en) begin
        g_nrd++;
        saddr_q.push_back(int'(smp_addr));
        caddr_q.push_back(int'(coef_addr));
      end
      if (res_valid) begin
        g_rcyc = n; g_data = res_data; g_id = int'(res_id); g_busy_res = busy;
        break;
      end
    end
    req[stage] = 1'b0;
    step();
    g_busy_after = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0; job_base = '0; job_coef = '0; job_taps = '0;
    repeat (3) step();
    total++; if ({grant, busy, rd_en, rd_sel} !== 7'd0) begin bad++;
      $display("FAIL reset_ctrl: got grant=%b busy=%b rd_en=%b rd_sel=%0d want 0", grant, busy, rd_en, rd_sel); end
    total++; if ({smp_addr, coef_addr} !== 14'd0) begin bad++;
      $display("FAIL reset_addr: got smp=%0d coef=%0d want 0", smp_addr, coef_addr); end
    total++; if ({res_valid, res_id, res_data} !== 19'd0) begin bad++;
      $display("FAIL reset_res: got v=%b id=%0d data=%h want 0", res_valid, res_id, res_data); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    clear_mem();
    for (int k = 0; k < 63; k++) cmem[k] = 16'(k + 1);
    smem[0][5] = 16'd1000;
    run_job(0, 5, 0, 63);
    total++; if (g_gcyc !== 1) begin bad++; $display("FAIL single_grant_cyc: got %0d want 1", g_gcyc); end
    total++; if (g_rcyc !== 65) begin bad++; $display("FAIL single_res_cyc: got %0d want 65", g_rcyc); end
    total++; if (g_data !== 16'd0) begin bad++; $display("FAIL single_data: got %h want 0000", g_data); end
    total++; if (g_nrd !== 63) begin bad++; $display("FAIL single_nrd: got %0d want 63", g_nrd); end
    total++; if (g_id !== 0) begin bad++; $display("FAIL single_id: got %0d want 0", g_id); end
    total++; if (g_busy_res !== 1'b1 || g_busy_after !== 1'b0) begin bad++;
      $display("FAIL single_busy: got res=%b after=%b want 1 0", g_busy_res, g_busy_after); end
    smem[0][5]  = 16'd0;
    smem[0][38] = 16'h7FFF;
    cmem[31]    = 16'h7FFF;
    run_job(0, 5, 0, 63);
    total++; if (g_data !== 16'd32766) begin bad++; $display("FAIL single_tap31: got %0d want 32766", g_data); end
  endtask

  task automatic test_wrap();
    int exp_s[5] = '{2, 1, 0, 63, 62};
    clear_mem();
    run_job(0, 2, 100, 5);
    total++; if (saddr_q.size() !== 5 || caddr_q.size() !== 5) begin bad++;
      $display("FAIL wrap_count: got %0d/%0d want 5", saddr_q.size(), caddr_q.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        total++; if (saddr_q[i] !== exp_s[i]) begin bad++;
          $display("FAIL wrap_smp[%0d]: got %0d want %0d", i, saddr_q[i], exp_s[i]); end
        total++; if (caddr_q[i] !== 100 + i) begin bad++;
          $display("FAIL wrap_coef[%0d]: got %0d want %0d", i, caddr_q[i], 100 + i); end
      end
    end
    total++; if (g_rcyc !== 7) begin bad++; $display("FAIL wrap_res_cyc: got %0d want 7", g_rcyc); end
  endtask

  task automatic test_arith();
    clear_mem();
    smem[1][10] = 16'h4000; smem[1][9] = 16'h4000; smem[1][8] = 16'hC000;
    cmem[200] = 16'd2; cmem[201] = 16'd4; cmem[202] = 16'd1;
    run_job(1, 10, 200, 3);
    total++; if (g_data !== 16'd2) begin bad++; $display("FAIL arith_pos: got %h want 0002", g_data); end
    total++; if (g_id !== 1) begin bad++; $display("FAIL arith_id: got %0d want 1", g_id); end
    smem[1][10] = 16'hC000; smem[1][9] = 16'hC000; smem[1][8] = 16'h4000;
    run_job(1, 10, 200, 3);
    total++; if (g_data !== 16'hFFFD) begin bad++; $display("FAIL arith_neg_floor: got %h want fffd", g_data); end
  endtask

  task automatic test_saturation();
    clear_mem();
    for (int a = 0; a < 64; a++) smem[0][a] = 16'h7FFF;
    for (int k = 0; k < 63; k++) cmem[k] = 16'h7FFF;
    run_job(0, 62, 0, 63);
    total++; if (g_data !== 16'h7FFF) begin bad++; $display("FAIL sat_pos: got %h want 7fff", g_data); end
    for (int a = 0; a < 64; a++) smem[0][a] = 16'h8001;
    run_job(0, 62, 0, 63);
    total++; if (g_data !== 16'h8000) begin bad++; $display("FAIL sat_neg: got %h want 8000", g_data); end
  endtask

  task automatic test_edge_taps();
    clear_mem();
    run_job(2, 7, 0, 0);
    total++; if (g_rcyc - g_gcyc !== 2 || g_gcyc !== 1) begin bad++;
      $display("FAIL zero_taps_timing: got grant=%0d res=%0d want 1 3", g_gcyc, g_rcyc); end
    total++; if (g_nrd !== 0) begin bad++; $display("FAIL zero_taps_rd: got %0d want 0", g_nrd); end
    total++; if (g_data !== 16'd0 || g_id !== 2) begin bad++;
      $display("FAIL zero_taps_res: got data=%h id=%0d want 0000 2", g_data, g_id); end
    run_job(0, 7, 0, 100);
    total++; if (g_nrd !== 63) begin bad++; $display("FAIL clamp_nrd: got %0d want 63", g_nrd); end
    total++; if (g_rcyc !== 65) begin bad++; $display("FAIL clamp_res_cyc: got %0d want 65", g_rcyc); end
  endtask

  task automatic test_reset_mid_job();
    int seen;
    clear_mem();
    job_base[5:0] = 6'd5; job_coef[7:0] = 8'd0; job_taps[6:0] = 7'd63;
    req[0] = 1'b1;
    step();
    total++; if (grant !== 3'b001) begin bad++; $display("FAIL rst_pre_grant: got %b want 001", grant); end
    req[0] = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    step();
    total++; if ({grant, busy, rd_en, rd_sel, smp_addr, coef_addr} !== 21'd0) begin bad++;
      $display("FAIL rst_mid_ctrl: got grant=%b busy=%b rd_en=%b smp=%0d coef=%0d want 0",
               grant, busy, rd_en, smp_addr, coef_addr); end
    total++; if ({res_valid, res_id, res_data} !== 19'd0) begin bad++;
      $display("FAIL rst_mid_res: got v=%b id=%0d data=%h want 0", res_valid, res_id, res_data); end
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 70; n++) begin
      step();
      if (res_valid || busy) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rst_no_result: got %0d active cycles want 0", seen); end
  endtask

  task automatic test_round_robin();
    int gidx[$];
    int gcyc[$];
    int rids[$];
    int non_onehot;
    int exp_g[4] = '{0, 1, 2, 0};
    int exp_c[4] = '{1, 7, 13, 19};
    non_onehot = 0;
    job_taps = {7'd3, 7'd3, 7'd3};
    job_base = {6'd20, 6'd10, 6'd0};
    job_coef = '0;
    req = 3'b111;
    for (int n = 1; n <= 60 && gidx.size() < 4; n++) begin
      step();
      if (grant != '0) begin
        if (!$onehot(grant)) non_onehot++;
        gidx.push_back(grant[0] ? 0 : grant[1] ? 1 : 2);
        gcyc.push_back(n);
      end
      if (res_valid) rids.push_back(int'(res_id));
    end
    req = '0;
    for (int n = 0; n < 20 && busy; n++) step();
    total++; if (gidx.size() !== 4 || non_onehot !== 0) begin bad++;
      $display("FAIL rr_grant_count: got %0d grants (%0d not one-hot) want 4", gidx.size(), non_onehot); end
    else begin
      for (int i = 0; i < 4; i++) begin
        total++; if (gidx[i] !== exp_g[i] || gcyc[i] !== exp_c[i]) begin bad++;
          $display("FAIL rr_grant[%0d]: got stage %0d at cycle %0d want stage %0d at cycle %0d",
                   i, gidx[i], gcyc[i], exp_g[i], exp_c[i]); end
      end
    end
    total++; if (rids.size() !== 3) begin bad++; $display("FAIL rr_res_count: got %0d want 3", rids.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        total++; if (rids[i] !== exp_g[i]) begin bad++;
          $display("FAIL rr_res_id[%0d]: got %0d want %0d", i, rids[i], exp_g[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_arith();
    test_saturation();
    test_edge_taps();
    test_reset_mid_job();
    test_round_robin();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
